// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
package bcd_pkg;
   localparam int BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;
endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand and result handshakes of the digit-serial BCD adder.
// The master side supplies operands and consumes results.
// The slave side is the controller.
interface bcd_serial_add_ctrl_if #(
   parameter int NDIGITS = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [4*NDIGITS-1:0] a;
   logic [4*NDIGITS-1:0] b;
   logic                 cin;
   logic                 out_valid;
   logic                 out_ready;
   logic [4*NDIGITS-1:0] sum;
   logic                 cout;
   logic                 err;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, err
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, err
   );
endinterface

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder.
// It is defined for any 4-bit inputs, including non-BCD codes.
module bcd_digit_adder
   import bcd_pkg::*;
(
   input  logic [3:0] da,
   input  logic [3:0] db,
   input  logic       c,
   output logic [3:0] ds,
   output logic       co
);
   logic [4:0] s;

   // Binary sum, then a +6 correction whenever the 5-bit sum exceeds nine.
   always_comb begin
      s  = {1'b0, da} + {1'b0, db} + {4'b0000, c};
      ds = s[3:0];
      co = 1'b0;
      if (s > {1'b0, BCD_MAX}) begin
         ds = s[3:0] + 4'd6;
         co = 1'b1;
      end
   end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller.
// It captures the operands, runs one shared digit adder from the LSD upward,
// and then holds the result until the consumer takes it.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input logic               clk,
   input logic               reset,
   bcd_serial_add_ctrl_if.slave bus
);
   localparam int W     = BCD_DIGIT_W * NDIGITS;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

   state_t           state;
   logic [W-1:0]     a_reg;
   logic [W-1:0]     b_reg;
   logic [W-1:0]     sum_reg;
   logic             carry_reg;
   logic [IDX_W-1:0] idx;
   logic             cout_reg;
   logic             err_reg;
   logic             out_valid_reg;
   logic             capture_err;
   logic [3:0]       digit_sum;
   logic             digit_carry;

   bcd_digit_adder u_digit (
      .da (a_reg[idx*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .db (b_reg[idx*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .c  (carry_reg),
      .ds (digit_sum),
      .co (digit_carry)
   );

   // Flag any non-BCD digit in the operands presented at capture time.
   always_comb begin
      capture_err = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if ((bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) ||
             (bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)) begin
            capture_err = 1'b1;
         end
      end
   end

   // Controller FSM: capture operands, ripple one digit per cycle, then hold the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         carry_reg     <= 1'b0;
         idx           <= '0;
         cout_reg      <= 1'b0;
         err_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  carry_reg <= bus.cin;
                  idx       <= '0;
                  err_reg   <= capture_err;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum_reg[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= digit_sum;
               carry_reg <= digit_carry;
               if (idx == LAST_IDX) begin
                  cout_reg      <= digit_carry;
                  out_valid_reg <= 1'b1;
                  state         <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
   assign bus.err       = err_reg;
endmodule
